// File: rtl/uart_core_param_if.sv
// Front-end bus bundle for uart_core_param.
// master = register/bus side, slave = UART core.
interface uart_core_param_if #(
  parameter int DBIT = 8
);
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            par_odd;
  logic            tx_busy;
  logic            tx_done;
  logic            rx_done;
  logic [DBIT-1:0] dout;
  logic            frame_err;
  logic            parity_err;

  modport master (
    output tx_start, din, par_odd,
    input  tx_busy, tx_done, rx_done,
    input  dout, frame_err, parity_err
  );

  modport slave (
    input  tx_start, din, par_odd,
    output tx_busy, tx_done, rx_done,
    output dout, frame_err, parity_err
  );
endinterface

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART core, 16x oversampling.
// Optional parity bit enabled by macro UART_PARITY_EN.
module uart_core_param #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              tx,
  input  logic              rx,
  uart_core_param_if.slave  bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_AFT   = S_PAR;
`else
  localparam logic [2:0] S_AFT   = S_STOP;
`endif
  localparam int SW = $clog2(SB_TICK > 16 ? SB_TICK : 16);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] C_MID = SW'(7);
  localparam logic [SW-1:0] C_END = SW'(15);
  localparam logic [SW-1:0] C_SB  = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LST = NW'(DBIT - 1);

  logic [DVSR_W-1:0] bcnt_q, bcnt_d, dvsr_q, dvsr_d;
  logic              tick;
  logic [2:0]        ts_q, ts_d, rs_q, rs_d;
  logic [SW-1:0]     tc_q, tc_d, rc_q, rc_d;
  logic [NW-1:0]     tn_q, tn_d, rn_q, rn_d;
  logic [DBIT-1:0]   tb_q, tb_d, rb_q, rb_d;
  logic [DBIT-1:0]   dout_q, dout_d;
  logic              tx_q, tx_d, tdone;
  logic [1:0]        rsync_q, rsync_d;
  logic              rxs, fe_now;
  logic              rfp_q, rfp_d, fe_q, fe_d;
  logic              rdone_q, rdone_d;
`ifdef UART_PARITY_EN
  logic              tp_q, tp_d, rpp_q, rpp_d;
  logic              pe_q, pe_d;
`else
  logic              unused_par;
  assign unused_par = bus.par_odd;
`endif

  // Baud tick: divisor reloaded only when the counter wraps
  always_comb begin
    tick   = (bcnt_q == dvsr_q);
    bcnt_d = tick ? '0 : bcnt_q + 1'b1;
    dvsr_d = tick ? dvsr : dvsr_q;
  end

  // Transmit FSM: start, data LSB first, parity, stop
  always_comb begin
    ts_d  = ts_q;
    tc_d  = tc_q;
    tn_d  = tn_q;
    tb_d  = tb_q;
    tx_d  = 1'b1;
    tdone = 1'b0;
`ifdef UART_PARITY_EN
    tp_d  = tp_q;
`endif
    unique case (ts_q)
      S_IDLE: if (bus.tx_start) begin
        ts_d = S_START;
        tc_d = '0;
        tb_d = bus.din;
`ifdef UART_PARITY_EN
        tp_d = ^bus.din ^ bus.par_odd;
`endif
      end
      S_START: begin
        tx_d = 1'b0;
        if (tick) begin
          if (tc_q == C_END) begin
            tc_d = '0;
            tn_d = '0;
            ts_d = S_DATA;
          end else tc_d = tc_q + 1'b1;
        end
      end
      S_DATA: begin
        tx_d = tb_q[0];
        if (tick) begin
          if (tc_q == C_END) begin
            tc_d = '0;
            tb_d = tb_q >> 1;
            if (tn_q == N_LST) ts_d = S_AFT;
            else tn_d = tn_q + 1'b1;
          end else tc_d = tc_q + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: begin
        tx_d = tp_q;
        if (tick) begin
          if (tc_q == C_END) begin
            tc_d = '0;
            ts_d = S_STOP;
          end else tc_d = tc_q + 1'b1;
        end
      end
`endif
      S_STOP: if (tick) begin
        if (tc_q == C_SB) begin
          tdone = 1'b1;
          ts_d  = S_IDLE;
        end else tc_d = tc_q + 1'b1;
      end
      default: ts_d = S_IDLE;
    endcase
  end

  // Receive FSM: sync, glitch-filtered start, mid-bit sampling
  always_comb begin
    rsync_d = {rsync_q[0], rx};
    rxs     = rsync_q[1];
    fe_now  = (rc_q == C_END) ? ~rxs : rfp_q;
    rs_d    = rs_q;
    rc_d    = rc_q;
    rn_d    = rn_q;
    rb_d    = rb_q;
    rfp_d   = rfp_q;
    dout_d  = dout_q;
    fe_d    = fe_q;
    rdone_d = 1'b0;
`ifdef UART_PARITY_EN
    rpp_d   = rpp_q;
    pe_d    = pe_q;
`endif
    unique case (rs_q)
      S_IDLE: if (!rxs) begin
        rs_d = S_START;
        rc_d = '0;
      end
      S_START: if (tick) begin
        if (rc_q == C_MID) begin
          if (!rxs) begin
            rs_d = S_DATA;
            rc_d = '0;
            rn_d = '0;
          end else rs_d = S_IDLE;
        end else rc_d = rc_q + 1'b1;
      end
      S_DATA: if (tick) begin
        if (rc_q == C_END) begin
          rc_d = '0;
          rb_d = {rxs, rb_q[DBIT-1:1]};
          if (rn_q == N_LST) rs_d = S_AFT;
          else rn_d = rn_q + 1'b1;
        end else rc_d = rc_q + 1'b1;
      end
`ifdef UART_PARITY_EN
      S_PAR: if (tick) begin
        if (rc_q == C_END) begin
          rc_d  = '0;
          rpp_d = rxs ^ (^rb_q) ^ bus.par_odd;
          rs_d  = S_STOP;
        end else rc_d = rc_q + 1'b1;
      end
`endif
      S_STOP: if (tick) begin
        rfp_d = fe_now;
        if (rc_q == C_SB) begin
          dout_d  = rb_q;
          fe_d    = fe_now;
          rdone_d = 1'b1;
          rs_d    = S_IDLE;
`ifdef UART_PARITY_EN
          pe_d    = rpp_q;
`endif
        end else rc_d = rc_q + 1'b1;
      end
      default: rs_d = S_IDLE;
    endcase
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q  <= '0;
      dvsr_q  <= '0;
      ts_q    <= S_IDLE;
      tc_q    <= '0;
      tn_q    <= '0;
      tb_q    <= '0;
      tx_q    <= 1'b1;
      rsync_q <= 2'b11;
      rs_q    <= S_IDLE;
      rc_q    <= '0;
      rn_q    <= '0;
      rb_q    <= '0;
      rfp_q   <= 1'b0;
      dout_q  <= '0;
      fe_q    <= 1'b0;
      rdone_q <= 1'b0;
`ifdef UART_PARITY_EN
      tp_q    <= 1'b0;
      rpp_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      bcnt_q  <= bcnt_d;
      dvsr_q  <= dvsr_d;
      ts_q    <= ts_d;
      tc_q    <= tc_d;
      tn_q    <= tn_d;
      tb_q    <= tb_d;
      tx_q    <= tx_d;
      rsync_q <= rsync_d;
      rs_q    <= rs_d;
      rc_q    <= rc_d;
      rn_q    <= rn_d;
      rb_q    <= rb_d;
      rfp_q   <= rfp_d;
      dout_q  <= dout_d;
      fe_q    <= fe_d;
      rdone_q <= rdone_d;
`ifdef UART_PARITY_EN
      tp_q    <= tp_d;
      rpp_q   <= rpp_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign tx            = tx_q;
  assign bus.tx_busy   = (ts_q != S_IDLE);
  assign bus.tx_done   = tdone;
  assign bus.rx_done   = rdone_q;
  assign bus.dout      = dout_q;
  assign bus.frame_err = fe_q;
`ifdef UART_PARITY_EN
  assign bus.parity_err = pe_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule
